// File: rtl/scale_apply_if.sv
// Request/response bundle for the scale_apply block.
// The master drives requests and consumes results; the slave is the scaler.
interface scale_apply_if #(
  parameter int unsigned MUL_BW = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               gemm_uno;
  logic signed [MUL_BW-1:0] acc_i;
  logic signed [MUL_BW-1:0] scale_i;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [MUL_BW-1:0] res_o;
  logic                     sat_o;
  logic                     busy_o;

  modport master (
    output in_valid, gemm_uno, acc_i, scale_i, out_ready,
    input  in_ready, out_valid, res_o, sat_o, busy_o
  );

  modport slave (
    input  in_valid, gemm_uno, acc_i, scale_i, out_ready,
    output in_ready, out_valid, res_o, sat_o, busy_o
  );
endinterface

// File: rtl/scale_apply.sv
// Applies a Q-format scale to a PE accumulator: pass-through (gemm), negate (log),
// or sign-magnitude shift-add multiply with truncation and saturation (div/exp).
module scale_apply #(
  parameter int unsigned INT_BW = 5,
  parameter int unsigned FRA_BW = 10,
  parameter int unsigned MUL_BW = 16
) (
  input logic          clk,
  input logic          rst,
  scale_apply_if.slave bus
);
  localparam int unsigned PW     = 2 * MUL_BW;
  localparam int unsigned CNT_BW = $clog2(MUL_BW);
  localparam logic [MUL_BW-1:0] MAX_POS = {1'b0, {(MUL_BW-1){1'b1}}};
  localparam logic [MUL_BW-1:0] MIN_NEG = {1'b1, {(MUL_BW-1){1'b0}}};

  if (MUL_BW != 1 + INT_BW + FRA_BW) begin : g_bad_cfg
    $error("scale_apply: MUL_BW must equal 1+INT_BW+FRA_BW");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       a_q, a_d;
  logic [MUL_BW-1:0]   b_q, b_d;
  logic [PW-1:0]       p_q, p_d;
  logic [CNT_BW-1:0]   cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [MUL_BW-1:0]   res_q, res_d;
  logic                sat_q, sat_d;

  logic [MUL_BW-1:0]   abs_acc;
  logic [MUL_BW-1:0]   abs_scale;
  logic [PW-1:0]       p_next;
  logic [PW-1:0]       q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    res_d     = res_q;
    sat_d     = sat_q;
    abs_acc   = bus.acc_i[MUL_BW-1]   ? MUL_BW'(-bus.acc_i)   : MUL_BW'(bus.acc_i);
    abs_scale = bus.scale_i[MUL_BW-1] ? MUL_BW'(-bus.scale_i) : MUL_BW'(bus.scale_i);
    p_next    = b_q[0] ? p_q + a_q : p_q;
    q         = p_next >> FRA_BW;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          unique case (bus.gemm_uno)
            2'b00: begin
              res_d   = MUL_BW'(bus.acc_i);
              sat_d   = 1'b0;
              state_d = DONE;
            end
            2'b11: begin
              // Only the most negative value has no positive counterpart.
              if (MUL_BW'(bus.acc_i) == MIN_NEG) begin
                res_d = MAX_POS;
                sat_d = 1'b1;
              end else begin
                res_d = MUL_BW'(-bus.acc_i);
                sat_d = 1'b0;
              end
              state_d = DONE;
            end
            default: begin
              a_d     = PW'(abs_acc);
              b_d     = abs_scale;
              p_d     = '0;
              cnt_d   = '0;
              neg_d   = bus.acc_i[MUL_BW-1] ^ bus.scale_i[MUL_BW-1];
              res_d   = '0;
              sat_d   = 1'b0;
              state_d = MUL;
            end
          endcase
        end
      end
      MUL: begin
        p_d   = p_next;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_BW'(1);
        // Last multiplier bit: truncate the magnitude, then clip into range.
        if (cnt_q == CNT_BW'(MUL_BW - 1)) begin
          state_d = DONE;
          if (!neg_q) begin
            sat_d = (q > PW'(MAX_POS));
            res_d = sat_d ? MAX_POS : MUL_BW'(q);
          end else begin
            sat_d = (q > PW'(MIN_NEG));
            res_d = sat_d ? MIN_NEG : MUL_BW'(-q);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.res_o     = res_q;
  assign bus.sat_o     = sat_q;
endmodule

// File: tb/tb_scale_apply.sv
// Directed, table-driven bench for scale_apply with backpressure and mid-op reset sequences.
module tb_scale_apply;
  localparam int unsigned MUL_BW = 16;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] acc;
    logic [15:0] scale;
    logic [15:0] res;
    logic        sat;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[18];

  always #5 clk = ~clk;

  scale_apply_if #(.MUL_BW(MUL_BW)) bus ();

  scale_apply #(.INT_BW(5), .FRA_BW(10), .MUL_BW(MUL_BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, measure latency inclusive of the accepting edge, consume immediately.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.gemm_uno  = v.op;
    bus.acc_i     = v.acc;
    bus.scale_i   = v.scale;
    bus.out_ready = 1'b1;
    chk({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.acc_i    = 16'($urandom);
    bus.scale_i  = 16'($urandom);
    bus.gemm_uno = 2'($urandom);
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      chk({tag, "_busy"}, 16'(bus.busy_o), 16'd1);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 16'(n), 16'(v.lat));
    chk({tag, "_res"}, $unsigned(bus.res_o), v.res);
    chk({tag, "_sat"}, 16'(bus.sat_o), 16'(v.sat));
    chk({tag, "_busy_done"}, 16'(bus.busy_o), 16'd1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid_clear"}, 16'(bus.out_valid), 16'd0);
    chk({tag, "_ready_again"}, 16'(bus.in_ready), 16'd1);
  endtask

  initial begin
    int n;
    vecs[0]  = '{2'b00, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1};
    vecs[1]  = '{2'b01, 16'h0800, 16'h0200, 16'h0400, 1'b0, 17};
    vecs[2]  = '{2'b10, 16'hFC00, 16'h0600, 16'hFA00, 1'b0, 17};
    vecs[3]  = '{2'b10, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 17};
    vecs[4]  = '{2'b11, 16'h0400, 16'h0000, 16'hFC00, 1'b0, 1};
    vecs[5]  = '{2'b11, 16'h8000, 16'h0000, 16'h7FFF, 1'b1, 1};
    vecs[6]  = '{2'b01, 16'h8000, 16'h0400, 16'h8000, 1'b0, 17};
    vecs[7]  = '{2'b01, 16'h8000, 16'h0401, 16'h8000, 1'b1, 17};
    vecs[8]  = '{2'b10, 16'h8000, 16'hFC00, 16'h7FFF, 1'b1, 17};
    vecs[9]  = '{2'b01, 16'h0000, 16'hFC00, 16'h0000, 1'b0, 17};
    vecs[10] = '{2'b01, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17};
    vecs[11] = '{2'b10, 16'hFC00, 16'h0001, 16'hFFFF, 1'b0, 17};
    vecs[12] = '{2'b01, 16'h0003, 16'hFE00, 16'hFFFF, 1'b0, 17};
    vecs[13] = '{2'b01, 16'h0C00, 16'hFE00, 16'hFA00, 1'b0, 17};
    vecs[14] = '{2'b00, 16'h8000, 16'h1111, 16'h8000, 1'b0, 1};
    vecs[15] = '{2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1};
    vecs[16] = '{2'b11, 16'h7FFF, 16'h0000, 16'h8001, 1'b0, 1};
    vecs[17] = '{2'b10, 16'hFC00, 16'hFC00, 16'h0400, 1'b0, 17};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.gemm_uno  = 2'b00;
    bus.acc_i     = '0;
    bus.scale_i   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_res", $unsigned(bus.res_o), 16'h0000);
    chk("rst_sat", 16'(bus.sat_o), 16'd0);
    chk("rst_busy", 16'(bus.busy_o), 16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 16'(bus.in_ready), 16'd1);

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held, no accept while DONE or on the consuming edge.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.gemm_uno  = 2'b01;
    bus.acc_i     = 16'h0C00;
    bus.scale_i   = 16'h0400;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("bp_latency", 16'(n), 16'd17);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus.in_valid = ~bus.in_valid;
      bus.gemm_uno = 2'b00;
      bus.acc_i    = 16'($urandom);
      bus.scale_i  = 16'($urandom);
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), 16'(bus.out_valid), 16'd1);
      chk($sformatf("bp_hold_res%0d", k), $unsigned(bus.res_o), 16'h0C00);
      chk($sformatf("bp_hold_sat%0d", k), 16'(bus.sat_o), 16'd0);
      chk($sformatf("bp_in_ready%0d", k), 16'(bus.in_ready), 16'd0);
    end
    bus.in_valid  = 1'b1;
    bus.gemm_uno  = 2'b00;
    bus.acc_i     = 16'h5555;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_consumed_valid", 16'(bus.out_valid), 16'd0);
    chk("bp_no_accept_busy", 16'(bus.busy_o), 16'd0);
    chk("bp_ready_again", 16'(bus.in_ready), 16'd1);
    bus.in_valid = 1'b0;

    // Reset in the middle of a multiply aborts it cleanly.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.gemm_uno = 2'b10;
    bus.acc_i    = 16'h0800;
    bus.scale_i  = 16'h0600;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("mrst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("mrst_busy", 16'(bus.busy_o), 16'd0);
    chk("mrst_res", $unsigned(bus.res_o), 16'h0000);
    chk("mrst_sat", 16'(bus.sat_o), 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_ready_after", 16'(bus.in_ready), 16'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("mrst_no_result", 16'(bus.out_valid), 16'd0);
    run_op('{2'b10, 16'h0800, 16'h0600, 16'h0C00, 1'b0, 17}, "mrst_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scale_apply.md
SCALE_APPLY -- requirements
Module: scale_apply

Interface
REQ-001 SHALL have parameter INT_BW, default 5, integer bits of the Q-format operand.
REQ-002 SHALL have parameter FRA_BW, default 10, fraction bits of the Q-format operand.
REQ-003 SHALL have parameter MUL_BW, default 16, operand/result width; MUL_BW = 1+INT_BW+FRA_BW.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, request valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts a request.
REQ-008 SHALL have port gemm_uno, input, 2, 00 gemm, 01 div, 10 exp, 11 log; sampled at accept.
REQ-009 SHALL have port acc_i, input, MUL_BW signed, accumulated PE result; sampled at accept.
REQ-010 SHALL have port scale_i, input, MUL_BW signed, scale from the PE scale generator; sampled at accept.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port res_o, output, MUL_BW signed, scaled result.
REQ-014 SHALL have port sat_o, output, 1, res_o was saturated; valid with out_valid.
REQ-015 SHALL have port busy_o, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DONE.
REQ-017 SHALL drive in_ready = (state==IDLE) and not rst; accept occurs on an edge with in_valid and in_ready both high.
REQ-018 SHALL, on accept, register gemm_uno, acc_i and scale_i; later input changes SHALL NOT affect the result.
REQ-019 SHALL, for gemm (00), set res_o=acc_i, sat_o=0, and enter DONE on the accepting edge.
REQ-020 SHALL, for log (11), set res_o=-acc_i and enter DONE on the accepting edge; acc_i=-2^(MUL_BW-1) SHALL yield 2^(MUL_BW-1)-1 with sat_o=1.
REQ-021 SHALL, for div (01) and exp (10), enter MUL and compute P=|acc|*|scale| (2*MUL_BW-bit unsigned) by radix-2 shift-add, one multiplier bit per cycle, exactly MUL_BW cycles in MUL.
REQ-022 SHALL form Q=P>>FRA_BW (truncation of magnitude, i.e. toward zero) and take sign = sign(acc) XOR sign(scale).
REQ-023 SHALL saturate: positive Q>2^(MUL_BW-1)-1 -> 2^(MUL_BW-1)-1; negative Q>2^(MUL_BW-1) -> -2^(MUL_BW-1); sat_o=1 when clipped, else 0.
REQ-024 SHALL produce a zero result as +0, sat_o=0, irrespective of the operand signs.
REQ-025 SHALL assert out_valid in DONE only; latency from the accepting edge to out_valid high SHALL be 1 edge for gemm/log and MUL_BW+1 edges for div/exp.
REQ-026 SHALL hold res_o, sat_o and out_valid stable in DONE until an edge with out_ready high, then go to IDLE with out_valid=0.
REQ-027 SHALL NOT accept a new request in the cycle a result is consumed; throughput is at most 1 result per 2 cycles for gemm/log and per MUL_BW+2 cycles for div/exp.
REQ-028 SHALL ignore out_ready outside DONE and in_valid outside IDLE.

Reset
REQ-029 SHALL, while rst is high, force state IDLE, in_ready=0, out_valid=0, res_o=0, sat_o=0, busy_o=0, and clear all internal registers.
REQ-030 SHALL, on rst asserted in MUL or DONE, abort the operation, discard the result, and after rst falls present in_ready=1 on the next cycle.

Verification
REQ-031 SHALL pass: gemm, acc_i=0x1234, out_ready=1 -> res_o=0x1234, sat_o=0, out_valid 1 edge after accept, in_ready high again 1 edge later.
REQ-032 SHALL pass: div, acc_i=0x0800 (2.0), scale_i=0x0200 (0.5) -> res_o=0x0400, sat_o=0, out_valid exactly 17 edges after accept, busy_o high throughout.
REQ-033 SHALL pass: exp, acc_i=0xFC00 (-1.0), scale_i=0x0600 (1.5) -> res_o=0xFA00; acc_i=0x7FFF, scale_i=0x7FFF -> res_o=0x7FFF, sat_o=1.
REQ-034 SHALL pass: log, acc_i=0x0400 -> res_o=0xFC00, sat_o=0; acc_i=0x8000 -> res_o=0x7FFF, sat_o=1.
REQ-035 SHALL pass: div result with out_ready low 5 cycles -> res_o/out_valid held, in_ready=0, inputs toggled without effect; consumed on the first edge with out_ready high.
REQ-036 SHALL pass: rst pulsed at MUL cycle 8 of an exp op -> all outputs 0 immediately, no out_valid for that op, next request accepted one cycle after rst falls and computes correctly.
